// File: rtl/gcd_pkg.sv
// Shared types and helpers for the streaming binary-GCD block.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } gcd_state_e;

    // Width of the RUN-cycle counter: must hold 4*WIDTH+1 plus headroom.
    function automatic int unsigned cyc_width(input int unsigned w);
        return $clog2(4 * w + 3);
    endfunction

endpackage

// File: rtl/gcd_core.sv
// Binary-GCD engine: FSM plus a/b/k/cnt datapath behind a start/busy/done interface.
module gcd_core
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WIDTH-1:0]              a_in,
    input  logic [WIDTH-1:0]              b_in,
    input  logic                          ack,
    output logic                          busy,
    output logic                          done,
    output logic [WIDTH-1:0]              result,
    output logic [cyc_width(WIDTH)-1:0]   cnt
);

    localparam int unsigned CYC_W = cyc_width(WIDTH);
    localparam int unsigned KW    = $clog2(WIDTH);

    gcd_state_e       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [KW-1:0]    k_q;
    logic [CYC_W-1:0] cnt_q;
    logic [WIDTH-1:0] result_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        k_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Terminating steps count as RUN cycles too.
                    if (a_q == '0) begin
                        result_q <= b_q << k_q;
                        state_q  <= DONE;
                    end else if (b_q == '0) begin
                        result_q <= a_q << k_q;
                        state_q  <= DONE;
                    end else if (a_q == b_q) begin
                        result_q <= a_q << k_q;
                        state_q  <= DONE;
                    end else if (!a_q[0] && !b_q[0]) begin
                        a_q <= a_q >> 1;
                        b_q <= b_q >> 1;
                        k_q <= k_q + 1'b1;
                    end else if (!a_q[0]) begin
                        a_q <= a_q >> 1;
                    end else if (!b_q[0]) begin
                        b_q <= b_q >> 1;
                    end else if (a_q > b_q) begin
                        a_q <= a_q - b_q;
                    end else begin
                        b_q <= b_q - a_q;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cnt    = cnt_q;

endmodule

// File: rtl/gcd_stream.sv
// Streaming GCD: input handshake into gcd_core, one-entry output buffer on the result side.
module gcd_stream
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              A,
    input  logic [WIDTH-1:0]              B,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              res,
    output logic [cyc_width(WIDTH)-1:0]   cycles,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int unsigned CYC_W = cyc_width(WIDTH);

    logic             core_busy;
    logic             core_done;
    logic [WIDTH-1:0] core_result;
    logic [CYC_W-1:0] core_cnt;
    logic             load;

    logic [WIDTH-1:0] res_q;
    logic [CYC_W-1:0] cyc_q;
    logic             out_valid_q;

    gcd_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (in_valid),
        .a_in   (A),
        .b_in   (B),
        .ack    (load),
        .busy   (core_busy),
        .done   (core_done),
        .result (core_result),
        .cnt    (core_cnt)
    );

    // Buffer takes the core result when empty or emptying on this same edge.
    assign load = core_done && (!out_valid_q || out_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q       <= '0;
            cyc_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (load) begin
            res_q       <= core_result;
            cyc_q       <= core_cnt;
            out_valid_q <= 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign in_ready  = !core_busy;
    assign res       = res_q;
    assign cycles    = cyc_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_gcd_stream.sv
// Self-checking bench for gcd_stream at WIDTH=8 (directed) and WIDTH=16 (randomized).
module tb_gcd_stream;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [7:0]  a8 = '0, b8 = '0, res8;
    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b1;
    logic [5:0]  cyc8;

    logic [15:0] a16 = '0, b16 = '0, res16;
    logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b1;
    logic [6:0]  cyc16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gcd_stream #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .A         (a8),
        .B         (b8),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .res       (res8),
        .cycles    (cyc8),
        .out_valid (ov8),
        .out_ready (or8)
    );

    gcd_stream #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .A         (a16),
        .B         (b16),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .res       (res16),
        .cycles    (cyc16),
        .out_valid (ov16),
        .out_ready (or16)
    );

    function automatic int unsigned ref_gcd(input int unsigned x, input int unsigned y);
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Present a pair from a negedge, hold it until accepted, then drop in_valid.
    task automatic send8(input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        a8 = a; b8 = b; iv8 = 1'b1;
        while (!ir8 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!ir8) begin
            checks++; errors++;
            $display("FAIL send8_timeout in_ready=%b required=1", ir8);
        end
        @(negedge clk);
        iv8 = 1'b0;
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b);
        int t = 0;
        a16 = a; b16 = b; iv16 = 1'b1;
        while (!ir16 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!ir16) begin
            checks++; errors++;
            $display("FAIL send16_timeout in_ready=%b required=1", ir16);
        end
        @(negedge clk);
        iv16 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++;
        if (ov8 !== 1'b0 || res8 !== 8'd0 || cyc8 !== 6'd0) begin
            errors++;
            $display("FAIL reset_outputs ov=%b res=%0d cyc=%0d required 0/0/0", ov8, res8, cyc8);
        end
        checks++;
        if (ov16 !== 1'b0 || res16 !== 16'd0 || cyc16 !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs16 ov=%b res=%0d cyc=%0d required 0/0/0",
                     ov16, res16, cyc16);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ir8 !== 1'b1 || ir16 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b%b required=11", ir8, ir16);
        end
    endtask

    task automatic test_single();
        int pulses = 0;
        logic [7:0] got_res = '0;
        logic [5:0] got_cyc = '0;
        or8 = 1'b1;
        send8(8'd25, 8'd15);
        for (int i = 0; i < 60; i++) begin
            if (ov8) begin
                if (pulses == 0) begin
                    got_res = res8;
                    got_cyc = cyc8;
                end
                pulses++;
            end
            @(negedge clk);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL single_pulses got=%0d required=1", pulses);
        end
        checks++;
        if (got_res !== 8'd5) begin
            errors++;
            $display("FAIL single_res got=%0d required=5", got_res);
        end
        checks++;
        if (got_cyc == 6'd0 || got_cyc > 6'd33) begin
            errors++;
            $display("FAIL single_cycles got=%0d required 1..33", got_cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pa [5] = '{8'd12, 8'd12, 8'd0, 8'd0, 8'd255};
        logic [7:0] pb [5] = '{8'd9, 8'd8, 8'd0, 8'd7, 8'd255};
        logic [7:0] er [5] = '{8'd3, 8'd4, 8'd0, 8'd7, 8'd255};
        logic [7:0] gr [$];
        logic [5:0] gc [$];
        or8 = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++) send8(pa[i], pb[i]);
            end
            begin
                for (int t = 0; t < 500 && gr.size() < 5; t++) begin
                    if (ov8 && or8) begin
                        gr.push_back(res8);
                        gc.push_back(cyc8);
                    end
                    @(negedge clk);
                end
            end
        join
        checks++;
        if (gr.size() != 5) begin
            errors++;
            $display("FAIL b2b_count got=%0d required=5", gr.size());
        end
        for (int i = 0; i < 5 && i < gr.size(); i++) begin
            checks++;
            if (gr[i] !== er[i]) begin
                errors++;
                $display("FAIL b2b_res[%0d] got=%0d required=%0d", i, gr[i], er[i]);
            end
            checks++;
            if (i >= 2) begin
                if (gc[i] !== 6'd1) begin
                    errors++;
                    $display("FAIL b2b_cycles[%0d] got=%0d required=1", i, gc[i]);
                end
            end else if (gc[i] == 6'd0 || gc[i] > 6'd33) begin
                errors++;
                $display("FAIL b2b_cycles[%0d] got=%0d required 1..33", i, gc[i]);
            end
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        logic [7:0] gr [$];
        or8 = 1'b0;
        send8(8'd48, 8'd36);
        send8(8'd17, 8'd5);
        for (int i = 0; i < 50; i++) begin
            if (ov8 !== 1'b1 || res8 !== 8'd12) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold unstable_cycles=%0d required=0", bad);
        end
        checks++;
        if (ir8 !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready got=%b required=0", ir8);
        end
        or8 = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (ov8 && or8) gr.push_back(res8);
            @(negedge clk);
        end
        checks++;
        if (gr.size() != 2) begin
            errors++;
            $display("FAIL stall_count got=%0d required=2", gr.size());
        end else begin
            checks++;
            if (gr[0] !== 8'd12 || gr[1] !== 8'd1) begin
                errors++;
                $display("FAIL stall_order got=%0d,%0d required=12,1", gr[0], gr[1]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int bad = 0;
        logic [7:0] gr [$];
        or8 = 1'b1;
        send8(8'd200, 8'd150);
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ir8 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_ready got=%b required=1", ir8);
        end
        for (int i = 0; i < 40; i++) begin
            if (ov8 !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_out_valid high_cycles=%0d required=0", bad);
        end
        send8(8'd9, 8'd6);
        for (int t = 0; t < 40; t++) begin
            if (ov8 && or8) gr.push_back(res8);
            @(negedge clk);
        end
        checks++;
        if (gr.size() != 1 || gr[0] !== 8'd3) begin
            errors++;
            $display("FAIL midrst_next count=%0d res=%0d required 1 result of 3",
                     gr.size(), (gr.size() > 0) ? gr[0] : 8'd0);
        end
    endtask

    task automatic test_random16();
        int unsigned exp_q [$];
        int got = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [15:0] a, b;
                    int unsigned sel;
                    int unsigned s;
                    sel = $urandom_range(0, 9);
                    a = 16'($urandom);
                    b = 16'($urandom);
                    if (sel == 0) a = '0;
                    else if (sel == 1) b = '0;
                    else if (sel == 2) b = a;
                    else if (sel == 3) begin
                        s = $urandom_range(0, 8);
                        a = 16'(($urandom & 32'hff) << s);
                        b = 16'(($urandom & 32'hff) << s);
                    end
                    exp_q.push_back(ref_gcd(int'(a), int'(b)));
                    send16(a, b);
                end
            end
            begin
                logic       hold = 1'b0;
                logic [15:0] pres = '0;
                logic [6:0]  pcyc = '0;
                int unsigned e;
                for (int t = 0; t < 80000 && got < 1000; t++) begin
                    if (hold) begin
                        checks++;
                        if (ov16 !== 1'b1 || res16 !== pres || cyc16 !== pcyc) begin
                            errors++;
                            $display("FAIL rand_stable ov=%b res=%0d cyc=%0d required 1/%0d/%0d",
                                     ov16, res16, cyc16, pres, pcyc);
                        end
                    end
                    or16 = ($urandom_range(0, 3) != 0);
                    if (ov16 && or16) begin
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hffff_ffff;
                        checks++;
                        if (32'(res16) !== e) begin
                            errors++;
                            $display("FAIL rand_res[%0d] got=%0d required=%0d", got, res16, e);
                        end
                        checks++;
                        if (cyc16 == 7'd0 || cyc16 > 7'd65) begin
                            errors++;
                            $display("FAIL rand_cycles[%0d] got=%0d required 1..65", got, cyc16);
                        end
                        got++;
                    end
                    hold = ov16 && !or16;
                    pres = res16;
                    pcyc = cyc16;
                    @(negedge clk);
                end
            end
        join
        checks++;
        if (got != 1000) begin
            errors++;
            $display("FAIL rand_count got=%0d required=1000", got);
        end
        or16 = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid_run();
        test_random16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
